// File: rtl/pulse_stretch_gen.sv
// pulse_stretch_gen
//   Turns one-cycle request strobes into clean fixed-width output pulses.
//   After each pulse the output is held low for a minimum gap. Strobes that
//   arrive while a pulse or gap is running are counted and replayed in order.
//   The pending counter saturates, and a dropped strobe sets a sticky overflow flag.
//
// Parameters
//   HIGH_CYCLES  cycles pulse_out is held high per pulse (>=1, <2**CNT_W)
//   GAP_CYCLES   minimum low cycles after each pulse (>=1, <2**CNT_W)
//   CNT_W        width of the phase counter
//   PEND_W       width of the pending-strobe counter
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   pulse_in   in   request strobe; a level counts once per cycle
//   clr_ovf    in   clears the sticky overflow flag
//   pulse_out  out  registered stretched pulse
//   busy       out  high while a pulse or its gap is in progress
//   pending    out  queued strobes that have not started yet
//   ovf        out  sticky flag: a strobe was dropped with pending full
module pulse_stretch_gen #(
    parameter int unsigned HIGH_CYCLES = 250,
    parameter int unsigned GAP_CYCLES  = 125,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clr_ovf,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam logic [CNT_W-1:0]  HighLast = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GapLast  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              pulse_q, busy_q;

    logic inc, deq, ovf_ev;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        inc     = 1'b0;
        deq     = 1'b0;
        ovf_ev  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The strobe is consumed directly; it never enters the queue.
                if (pulse_in) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end
            end
            StHigh: begin
                inc = pulse_in;
                if (cnt_q == HighLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    // With an empty queue a strobe here starts the next pulse
                    // directly; otherwise the queue head starts it and the
                    // strobe takes its place in the queue.
                    deq     = (pend_q != '0);
                    inc     = pulse_in && (pend_q != '0);
                    state_d = ((pend_q != '0) || pulse_in) ? StHigh : StIdle;
                    cnt_d   = '0;
                end else begin
                    inc   = pulse_in;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (inc && !deq) begin
            if (pend_q == PendMax) begin
                ovf_ev = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (deq && !inc) begin
            pend_d = pend_q - 1'b1;
        end

        // Setting wins over clearing in the same cycle.
        if (ovf_ev) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            // Outputs are decoded from the next state so they stay registered.
            pulse_q <= (state_d == StHigh);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;

endmodule
